frame_decode_multi: RTL and testbench



---
 rtl/frame_decode_multi.sv | 212 +++++++++++++++++++++
 tb/tb_frame_decode_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_decode_multi.sv
// rtl/frame_decode_multi.sv - Miller-symbol to ISO 14443A frame decoder with parity, CRC_A and length guard
`timescale 1ns/1ps
module frame_decode_multi #(
    parameter bit PARITY_EN = 1'b1,
    parameter bit CRC_EN    = 1'b1,
    parameter int MAX_BYTES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seq_valid,
    input  logic [1:0] seq,
    output logic       soc,
    output logic       eoc,
    output logic [7:0] data,
    output logic [2:0] data_bits,
    output logic       data_valid,
    output logic       parity_error,
    output logic       sequence_error,
    output logic       overflow_error,
    output logic       crc_ok
);

    localparam logic [1:0] SEQ_X   = 2'd0;
    localparam logic [1:0] SEQ_Y   = 2'd1;
    localparam logic [1:0] SEQ_Z   = 2'd2;
    localparam logic [1:0] SEQ_ERR = 2'd3;
    localparam logic [7:0] MAX_B   = 8'(MAX_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERROR} state_t;

    state_t      state_q, state_d;
    logic        prev_x_q, prev_x_d;
    logic        pend_q, pend_d;
    logic [7:0]  sh_q, sh_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] crc_q, crc_d;
    logic        soc_q, soc_d;
    logic        eoc_q, eoc_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  data_bits_q, data_bits_d;
    logic        data_valid_q, data_valid_d;
    logic        parity_error_q, parity_error_d;
    logic        sequence_error_q, sequence_error_d;
    logic        overflow_error_q, overflow_error_d;
    logic        crc_ok_q, crc_ok_d;

    logic [1:0]  commit;
    logic [1:0]  cbit;
    logic        byte_done;

    function automatic logic [15:0] crc_a_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        state_d          = state_q;
        prev_x_d         = prev_x_q;
        pend_d           = pend_q;
        sh_d             = sh_q;
        bit_cnt_d        = bit_cnt_q;
        byte_cnt_d       = byte_cnt_q;
        crc_d            = crc_q;
        soc_d            = 1'b0;
        eoc_d            = 1'b0;
        data_d           = data_q;
        data_bits_d      = 3'd0;
        data_valid_d     = 1'b0;
        parity_error_d   = 1'b0;
        sequence_error_d = 1'b0;
        overflow_error_d = 1'b0;
        crc_ok_d         = 1'b0;
        commit           = 2'b00;
        cbit             = 2'b10;
        byte_done        = 1'b0;

        if (seq_valid) begin
            prev_x_d = (seq == SEQ_X);
            case (state_q)
                S_IDLE: begin
                    if (seq == SEQ_Z) begin
                        soc_d      = 1'b1;
                        state_d    = S_DATA;
                        pend_d     = 1'b0;
                        sh_d       = 8'd0;
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = 8'd0;
                        crc_d      = 16'h6363;
                    end
                end
                S_DATA: begin
                    if (seq == SEQ_ERR) begin
                        sequence_error_d = 1'b1;
                        state_d          = S_ERROR;
                        pend_d           = 1'b0;
                    end else if (seq == SEQ_Y && !prev_x_q) begin
                        // End of communication: any pending 0 belongs to the EOC pattern
                        eoc_d   = 1'b1;
                        pend_d  = 1'b0;
                        state_d = S_IDLE;
                        if (bit_cnt_q == 4'd0 && byte_cnt_q == 8'd0) begin
                            sequence_error_d = 1'b1;
                        end else if (bit_cnt_q != 4'd0 && bit_cnt_q < 4'd8) begin
                            data_bits_d = bit_cnt_q[2:0];
                            data_d      = sh_q;
                        end else if (bit_cnt_q == 4'd8) begin
                            parity_error_d = 1'b1;
                        end
                        crc_ok_d = CRC_EN && (byte_cnt_q >= 8'd3) &&
                                   (bit_cnt_q == 4'd0) && (crc_q == 16'h0000);
                    end else begin
                        // Slot 0 flushes the held 0, slot 1 carries an X's 1
                        commit = {seq == SEQ_X, pend_q};
                        pend_d = (seq != SEQ_X);
                    end
                end
                S_ERROR: begin
                    if (seq == SEQ_Y && !prev_x_q) begin
                        eoc_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        for (int k = 0; k < 2; k++) begin
            byte_done = 1'b0;
            if (commit[k] && state_d == S_DATA) begin
                if (bit_cnt_d == 4'd0 && byte_cnt_d == MAX_B) begin
                    overflow_error_d = 1'b1;
                    state_d          = S_ERROR;
                    pend_d           = 1'b0;
                end else if (bit_cnt_d < 4'd8) begin
                    if (bit_cnt_d == 4'd0) begin
                        sh_d = 8'd0;
                    end
                    sh_d[bit_cnt_d[2:0]] = cbit[k];
                    bit_cnt_d = bit_cnt_d + 4'd1;
                    byte_done = !PARITY_EN && (bit_cnt_d == 4'd8);
                end else if (cbit[k] != ~^sh_d) begin
                    parity_error_d = 1'b1;
                    state_d        = S_ERROR;
                    pend_d         = 1'b0;
                end else begin
                    byte_done = 1'b1;
                end
                if (byte_done) begin
                    data_valid_d = 1'b1;
                    data_d       = sh_d;
                    crc_d        = CRC_EN ? crc_a_byte(crc_d, sh_d) : crc_d;
                    byte_cnt_d   = byte_cnt_d + 8'd1;
                    bit_cnt_d    = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            prev_x_q         <= 1'b0;
            pend_q           <= 1'b0;
            sh_q             <= 8'd0;
            bit_cnt_q        <= 4'd0;
            byte_cnt_q       <= 8'd0;
            crc_q            <= 16'h6363;
            soc_q            <= 1'b0;
            eoc_q            <= 1'b0;
            data_q           <= 8'd0;
            data_bits_q      <= 3'd0;
            data_valid_q     <= 1'b0;
            parity_error_q   <= 1'b0;
            sequence_error_q <= 1'b0;
            overflow_error_q <= 1'b0;
            crc_ok_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            prev_x_q         <= prev_x_d;
            pend_q           <= pend_d;
            sh_q             <= sh_d;
            bit_cnt_q        <= bit_cnt_d;
            byte_cnt_q       <= byte_cnt_d;
            crc_q            <= crc_d;
            soc_q            <= soc_d;
            eoc_q            <= eoc_d;
            data_q           <= data_d;
            data_bits_q      <= data_bits_d;
            data_valid_q     <= data_valid_d;
            parity_error_q   <= parity_error_d;
            sequence_error_q <= sequence_error_d;
            overflow_error_q <= overflow_error_d;
            crc_ok_q         <= crc_ok_d;
        end
    end

    assign soc            = soc_q;
    assign eoc            = eoc_q;
    assign data           = data_q;
    assign data_bits      = data_bits_q;
    assign data_valid     = data_valid_q;
    assign parity_error   = parity_error_q;
    assign sequence_error = sequence_error_q;
    assign overflow_error = overflow_error_q;
    assign crc_ok         = crc_ok_q;

endmodule

// File: tb/tb_frame_decode_multi.sv
// tb/tb_frame_decode_multi.sv - directed self-checking bench for frame_decode_multi
`timescale 1ns/1ps
module tb_frame_decode_multi;

    localparam logic [1:0] SX = 2'd0;
    localparam logic [1:0] SY = 2'd1;
    localparam logic [1:0] SZ = 2'd2;
    localparam logic [1:0] SE = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] seq = 2'd0;
    logic       seq_valid = 1'b0;
    int         tgt = 0;

    logic       va, vb, vc;
    logic       soc_w [3];
    logic       eoc_w [3];
    logic [7:0] data_w [3];
    logic [2:0] bits_w [3];
    logic       dv_w [3];
    logic       pe_w [3];
    logic       se_w [3];
    logic       ovf_w [3];
    logic       crc_w [3];

    always #5 clk = ~clk;

    assign va = seq_valid && (tgt == 0);
    assign vb = seq_valid && (tgt == 1);
    assign vc = seq_valid && (tgt == 2);

    frame_decode_multi u_dflt (
        .clk(clk), .rst_n(rst_n), .seq_valid(va), .seq(seq),
        .soc(soc_w[0]), .eoc(eoc_w[0]), .data(data_w[0]), .data_bits(bits_w[0]),
        .data_valid(dv_w[0]), .parity_error(pe_w[0]), .sequence_error(se_w[0]),
        .overflow_error(ovf_w[0]), .crc_ok(crc_w[0])
    );

    frame_decode_multi #(.PARITY_EN(1'b1), .CRC_EN(1'b1), .MAX_BYTES(2)) u_max2 (
        .clk(clk), .rst_n(rst_n), .seq_valid(vb), .seq(seq),
        .soc(soc_w[1]), .eoc(eoc_w[1]), .data(data_w[1]), .data_bits(bits_w[1]),
        .data_valid(dv_w[1]), .parity_error(pe_w[1]), .sequence_error(se_w[1]),
        .overflow_error(ovf_w[1]), .crc_ok(crc_w[1])
    );

    frame_decode_multi #(.PARITY_EN(1'b0), .CRC_EN(1'b1), .MAX_BYTES(2)) u_nopar (
        .clk(clk), .rst_n(rst_n), .seq_valid(vc), .seq(seq),
        .soc(soc_w[2]), .eoc(eoc_w[2]), .data(data_w[2]), .data_bits(bits_w[2]),
        .data_valid(dv_w[2]), .parity_error(pe_w[2]), .sequence_error(se_w[2]),
        .overflow_error(ovf_w[2]), .crc_ok(crc_w[2])
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    bit         last_x = 1'b0;
    logic       o_soc, o_eoc, o_pe, o_se, o_ovf;
    logic [7:0] rx_q [$];
    int         n_eoc, n_pe, n_se, n_ovf, n_soc, n_dv_eoc;
    logic [7:0] e_data;
    logic [2:0] e_bits;
    logic       e_crc;
    logic [7:0] rx_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rx_q.delete();
        n_eoc = 0; n_pe = 0; n_se = 0; n_ovf = 0; n_soc = 0; n_dv_eoc = 0;
        e_data = 8'hxx; e_bits = 3'bxxx; e_crc = 1'bx;
    endtask

    task automatic step(input logic [1:0] s);
        @(negedge clk);
        seq = s;
        seq_valid = 1'b1;
        last_x = (s == SX);
        @(posedge clk);
        #1;
        seq_valid = 1'b0;
        o_soc = soc_w[tgt];
        o_eoc = eoc_w[tgt];
        o_pe  = pe_w[tgt];
        o_se  = se_w[tgt];
        o_ovf = ovf_w[tgt];
        if (dv_w[tgt]) rx_q.push_back(data_w[tgt]);
        if (dv_w[tgt] && eoc_w[tgt]) n_dv_eoc++;
        if (o_eoc) begin
            n_eoc++;
            e_data = data_w[tgt];
            e_bits = bits_w[tgt];
            e_crc  = crc_w[tgt];
        end
        n_soc += int'(o_soc);
        n_pe  += int'(o_pe);
        n_se  += int'(o_se);
        n_ovf += int'(o_ovf);
    endtask

    task automatic sbit(input logic b);
        step(b ? SX : (last_x ? SY : SZ));
    endtask

    task automatic sbyte(input logic [7:0] v, input logic par, input logic flip);
        for (int i = 0; i < 8; i++) sbit(v[i]);
        if (par) sbit((~^v) ^ flip);
    endtask

    task automatic sof();
        clr();
        step(SZ);
    endtask

    task automatic eof();
        sbit(1'b0);
        step(SY);
    endtask

    function automatic logic [7:0] rx(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    initial begin
        clr();
        tgt = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_soc", soc_w[0], 1'b0);
        chk("reset_eoc", eoc_w[0], 1'b0);
        chk("reset_data", data_w[0], 8'h00);
        chk("reset_dv", dv_w[0], 1'b0);
        chk("reset_crc_ok", crc_w[0], 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty frame
        clr();
        step(SZ);
        chk("t1_soc", o_soc, 1'b1);
        step(SY);
        chk("t1_eoc", o_eoc, 1'b1);
        chk("t1_seq_err", o_se, 1'b1);
        step(SY);
        chk("t1_idle_eoc", o_eoc, 1'b0);
        chk("t1_no_dv", rx_q.size(), 0);

        // CRC_A residue frame, then a corrupted last byte
        sof();
        sbyte(8'h00, 1, 0); sbyte(8'h00, 1, 0); sbyte(8'hA0, 1, 0); sbyte(8'h1E, 1, 0);
        eof();
        chk("t2_dv_cnt", rx_q.size(), 4);
        chk("t2_b0", rx(0), 8'h00);
        chk("t2_b2", rx(2), 8'hA0);
        chk("t2_b3", rx(3), 8'h1E);
        chk("t2_eoc_cnt", n_eoc, 1);
        chk("t2_bits", e_bits, 3'd0);
        chk("t2_crc_ok", e_crc, 1'b1);
        chk("t2_pe", n_pe, 0);
        sof();
        sbyte(8'h00, 1, 0); sbyte(8'h00, 1, 0); sbyte(8'hA0, 1, 0); sbyte(8'h1F, 1, 0);
        eof();
        chk("t2b_dv_cnt", rx_q.size(), 4);
        chk("t2b_b3", rx(3), 8'h1F);
        chk("t2b_crc_ok", e_crc, 1'b0);
        chk("t2b_eoc_cnt", n_eoc, 1);

        // REQA short frame
        sof();
        rx_byte = 8'h26;
        for (int i = 0; i < 7; i++) sbit(rx_byte[i]);
        eof();
        chk("t3_dv_cnt", rx_q.size(), 0);
        chk("t3_bits", e_bits, 3'd7);
        chk("t3_data", e_data, 8'h26);
        chk("t3_crc_ok", e_crc, 1'b0);
        chk("t3_eoc_cnt", n_eoc, 1);

        // Bad parity on 0x93; the flipped 0 is committed by the next symbol
        sof();
        sbyte(8'h93, 1, 1);
        rx_byte = 8'h55;
        sbit(rx_byte[0]);
        chk("t4_pe_pulse", o_pe, 1'b1);
        for (int i = 1; i < 8; i++) sbit(rx_byte[i]);
        sbit(~^rx_byte);
        eof();
        chk("t4_pe_cnt", n_pe, 1);
        chk("t4_dv_cnt", rx_q.size(), 0);
        chk("t4_eoc_cnt", n_eoc, 1);
        chk("t4_bits", e_bits, 3'd0);
        chk("t4_se_cnt", n_se, 0);

        // Illegal symbol in the second byte
        sof();
        sbyte(8'h12, 1, 0);
        sbit(1'b0); sbit(1'b1); sbit(1'b1); sbit(1'b1);
        step(SE);
        chk("t5_se_pulse", o_se, 1'b1);
        eof();
        chk("t5_dv_cnt", rx_q.size(), 1);
        chk("t5_b0", rx(0), 8'h12);
        chk("t5_se_cnt", n_se, 1);
        chk("t5_eoc_cnt", n_eoc, 1);
        chk("t5_crc_ok", e_crc, 1'b0);

        // Overflow with MAX_BYTES=2
        tgt = 1;
        sof();
        sbyte(8'h11, 1, 0); sbyte(8'h22, 1, 0);
        rx_byte = 8'h33;
        sbit(rx_byte[0]);
        chk("t6_ovf_pulse", o_ovf, 1'b1);
        for (int i = 1; i < 8; i++) sbit(rx_byte[i]);
        sbit(~^rx_byte);
        eof();
        chk("t6_dv_cnt", rx_q.size(), 2);
        chk("t6_b1", rx(1), 8'h22);
        chk("t6_ovf_cnt", n_ovf, 1);
        chk("t6_eoc_cnt", n_eoc, 1);

        // Plain 8-bit characters, exactly MAX_BYTES bytes
        tgt = 2;
        sof();
        sbyte(8'hA5, 0, 0); sbyte(8'h3C, 0, 0);
        eof();
        chk("t6b_dv_cnt", rx_q.size(), 2);
        chk("t6b_b0", rx(0), 8'hA5);
        chk("t6b_b1", rx(1), 8'h3C);
        chk("t6b_pe", n_pe, 0);
        chk("t6b_ovf", n_ovf, 0);
        chk("t6b_eoc_cnt", n_eoc, 1);
        chk("t6b_bits", e_bits, 3'd0);

        // Reset in mid-frame: no eoc, and the decoder is back in IDLE
        tgt = 0;
        sof();
        sbit(1'b1); sbit(1'b0); sbit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_eoc", eoc_w[0], 1'b0);
        chk("rst_mid_dv", dv_w[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        step(SY);
        chk("rst_mid_idle_eoc", o_eoc, 1'b0);
        step(SX);
        chk("rst_mid_idle_soc", o_soc, 1'b0);
        chk("dv_eoc_overlap", n_dv_eoc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
